// File: rtl/marx_resp_router.sv
// marx_resp_router: tracks the owning CPU of each in-flight op per APU resource and routes
// returning results to that CPU through a registered, back-pressured per-CPU output slot.
module marx_resp_router #(
    parameter int unsigned NIN   = 4,
    parameter int unsigned NOUT  = 2,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WDATA = 32,
    parameter int unsigned NIN2  = (NIN > 1) ? $clog2(NIN) : 1
) (
    input  logic                  clk_ci,
    input  logic                  rst_rbi,
    input  logic [NOUT-1:0]       alloc_di,
    input  logic [NOUT*NIN2-1:0]  assid_di,
    input  logic [NOUT-1:0]       unit_ready_di,
    output logic [NOUT-1:0]       avail_do,
    input  logic [NOUT-1:0]       res_valid_di,
    input  logic [NOUT*WDATA-1:0] res_data_di,
    output logic [NOUT-1:0]       res_ready_do,
    output logic [NIN-1:0]        cpu_valid_do,
    output logic [NIN*WDATA-1:0]  cpu_data_do,
    input  logic [NIN-1:0]        cpu_ready_di,
    output logic                  err_so
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH + 1);
    localparam int unsigned JW   = (NOUT > 1) ? $clog2(NOUT) : 1;

    typedef logic [NIN2-1:0]  id_t;
    typedef logic [WDATA-1:0] data_t;
    typedef logic [PTRW-1:0]  ptr_t;
    typedef logic [CNTW-1:0]  cnt_t;

    id_t             fifo_q   [NOUT][DEPTH];
    ptr_t            wr_ptr_q [NOUT];
    ptr_t            wr_ptr_d [NOUT];
    ptr_t            rd_ptr_q [NOUT];
    ptr_t            rd_ptr_d [NOUT];
    cnt_t            cnt_q    [NOUT];
    cnt_t            cnt_d    [NOUT];
    id_t             head     [NOUT];
    data_t           res_data [NOUT];
    logic [NOUT-1:0] full;
    logic [NOUT-1:0] empty;
    logic [NOUT-1:0] push;
    logic [NOUT-1:0] pop;
    logic [NOUT-1:0] orphan;

    logic [NIN-1:0]  slot_free;
    logic [NIN-1:0]  win_vld;
    logic [NIN-1:0]  load;
    logic [JW-1:0]   win_idx    [NIN];
    logic [NIN-1:0]  cpu_valid_q;
    logic [NIN-1:0]  cpu_valid_d;
    data_t           cpu_data_q [NIN];
    data_t           cpu_data_d [NIN];
    logic            err_q;
    logic            err_d;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // FIFO status, availability towards the allocator and accepted pushes.
    always_comb begin
        full     = '0;
        empty    = '0;
        avail_do = '0;
        push     = '0;
        orphan   = '0;
        for (int j = 0; j < NOUT; j++) begin
            full[j]     = (cnt_q[j] == cnt_t'(DEPTH));
            empty[j]    = (cnt_q[j] == '0);
            head[j]     = fifo_q[j][rd_ptr_q[j]];
            res_data[j] = res_data_di[j*WDATA +: WDATA];
            avail_do[j] = unit_ready_di[j] & ~full[j];
            push[j]     = alloc_di[j] & avail_do[j];
            orphan[j]   = res_valid_di[j] & empty[j];
        end
    end

    // Per-CPU arbitration: lowest-indexed resource whose head belongs to that CPU wins.
    always_comb begin
        win_vld      = '0;
        slot_free    = '0;
        load         = '0;
        res_ready_do = '0;
        for (int i = 0; i < NIN; i++) begin
            win_idx[i] = '0;
            for (int j = NOUT - 1; j >= 0; j--) begin
                if (res_valid_di[j] && !empty[j] && (head[j] == id_t'(i))) begin
                    win_vld[i] = 1'b1;
                    win_idx[i] = JW'(j);
                end
            end
            slot_free[i] = ~cpu_valid_q[i] | cpu_ready_di[i];
            load[i]      = win_vld[i] & slot_free[i];
            if (load[i]) begin
                res_ready_do[win_idx[i]] = 1'b1;
            end
        end
        // Orphans are always consumed so a misbehaving APU cannot wedge the resource.
        res_ready_do = res_ready_do | orphan;
        pop          = res_valid_di & res_ready_do & ~empty;
    end

    always_comb begin
        for (int j = 0; j < NOUT; j++) begin
            wr_ptr_d[j] = wr_ptr_q[j];
            rd_ptr_d[j] = rd_ptr_q[j];
            cnt_d[j]    = cnt_q[j];
            if (push[j]) begin
                wr_ptr_d[j] = ptr_inc(wr_ptr_q[j]);
            end
            if (pop[j]) begin
                rd_ptr_d[j] = ptr_inc(rd_ptr_q[j]);
            end
            case ({push[j], pop[j]})
                2'b10:   cnt_d[j] = cnt_q[j] + cnt_t'(1);
                2'b01:   cnt_d[j] = cnt_q[j] - cnt_t'(1);
                default: cnt_d[j] = cnt_q[j];
            endcase
        end
    end

    always_comb begin
        cpu_valid_d = cpu_valid_q;
        for (int i = 0; i < NIN; i++) begin
            cpu_data_d[i] = cpu_data_q[i];
            if (load[i]) begin
                cpu_valid_d[i] = 1'b1;
                cpu_data_d[i]  = res_data[win_idx[i]];
            end else if (cpu_ready_di[i]) begin
                cpu_valid_d[i] = 1'b0;
            end
        end
        err_d = err_q | (|orphan);
    end

    always_ff @(posedge clk_ci or negedge rst_rbi) begin
        if (!rst_rbi) begin
            for (int j = 0; j < NOUT; j++) begin
                wr_ptr_q[j] <= '0;
                rd_ptr_q[j] <= '0;
                cnt_q[j]    <= '0;
            end
            for (int i = 0; i < NIN; i++) begin
                cpu_data_q[i] <= '0;
            end
            cpu_valid_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int j = 0; j < NOUT; j++) begin
                wr_ptr_q[j] <= wr_ptr_d[j];
                rd_ptr_q[j] <= rd_ptr_d[j];
                cnt_q[j]    <= cnt_d[j];
            end
            for (int i = 0; i < NIN; i++) begin
                cpu_data_q[i] <= cpu_data_d[i];
            end
            cpu_valid_q <= cpu_valid_d;
            err_q       <= err_d;
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk_ci) begin
        for (int j = 0; j < NOUT; j++) begin
            if (push[j]) begin
                fifo_q[j][wr_ptr_q[j]] <= assid_di[j*NIN2 +: NIN2];
            end
        end
    end

    always_comb begin
        cpu_data_do = '0;
        for (int i = 0; i < NIN; i++) begin
            cpu_data_do[i*WDATA +: WDATA] = cpu_data_q[i];
        end
    end

    assign cpu_valid_do = cpu_valid_q;
    assign err_so       = err_q;

`ifndef SYNTHESIS
    for (genvar j = 0; j < NOUT; j++) begin : g_fifo_chk
        a_no_push_full : assert property (@(posedge clk_ci) disable iff (!rst_rbi)
            !(push[j] && full[j]));
        a_cnt_bound : assert property (@(posedge clk_ci) disable iff (!rst_rbi)
            cnt_q[j] <= cnt_t'(DEPTH));
    end
`endif

endmodule

// File: tb/tb_marx_resp_router.sv
// Scoreboard bench for marx_resp_router: queue-based reference of ID FIFOs and CPU slots,
// directed scenarios followed by randomized traffic, drain and mid-traffic reset.
module tb_marx_resp_router;

    localparam int NIN   = 4;
    localparam int NOUT  = 2;
    localparam int DEPTH = 2;
    localparam int WDATA = 32;
    localparam int NIN2  = 2;

    logic                  clk_ci = 1'b0;
    logic                  rst_rbi = 1'b0;
    logic [NOUT-1:0]       alloc_di = '0;
    logic [NOUT*NIN2-1:0]  assid_di = '0;
    logic [NOUT-1:0]       unit_ready_di = '0;
    logic [NOUT-1:0]       avail_do;
    logic [NOUT-1:0]       res_valid_di = '0;
    logic [NOUT*WDATA-1:0] res_data_di = '0;
    logic [NOUT-1:0]       res_ready_do;
    logic [NIN-1:0]        cpu_valid_do;
    logic [NIN*WDATA-1:0]  cpu_data_do;
    logic [NIN-1:0]        cpu_ready_di = '0;
    logic                  err_so;

    always #5 clk_ci = ~clk_ci;

    marx_resp_router #(
        .NIN(NIN), .NOUT(NOUT), .DEPTH(DEPTH), .WDATA(WDATA), .NIN2(NIN2)
    ) dut (
        .clk_ci        (clk_ci),
        .rst_rbi       (rst_rbi),
        .alloc_di      (alloc_di),
        .assid_di      (assid_di),
        .unit_ready_di (unit_ready_di),
        .avail_do      (avail_do),
        .res_valid_di  (res_valid_di),
        .res_data_di   (res_data_di),
        .res_ready_do  (res_ready_do),
        .cpu_valid_do  (cpu_valid_do),
        .cpu_data_do   (cpu_data_do),
        .cpu_ready_di  (cpu_ready_di),
        .err_so        (err_so)
    );

    // Stimulus for the next cycle; copied onto the DUT inputs at the falling edge.
    logic [NOUT-1:0]       s_alloc = '0;
    logic [NOUT*NIN2-1:0]  s_assid = '0;
    logic [NOUT-1:0]       s_uready = '0;
    logic [NOUT-1:0]       s_rvalid = '0;
    logic [NOUT*WDATA-1:0] s_rdata = '0;
    logic [NIN-1:0]        s_cready = '0;

    int total = 0;
    int bad   = 0;

    // Reference: outstanding owner IDs per resource, pending results per CPU, slot occupancy.
    int               mq   [NOUT][$];
    logic [WDATA-1:0] expq [NIN][$];
    logic [NIN-1:0]   slot_m = '0;
    logic             err_m  = 1'b0;
    logic [NOUT-1:0]  acc    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        int              win [NIN];
        int              h;
        logic [NOUT-1:0] exp_av;
        logic [NOUT-1:0] exp_rdy;
        logic [NIN-1:0]  loaded;
        @(negedge clk_ci);
        alloc_di      = s_alloc;
        assid_di      = s_assid;
        unit_ready_di = s_uready;
        res_valid_di  = s_rvalid;
        res_data_di   = s_rdata;
        cpu_ready_di  = s_cready;
        #2;
        for (int i = 0; i < NIN; i++) win[i] = -1;
        for (int j = 0; j < NOUT; j++) begin
            exp_av[j] = s_uready[j] && (mq[j].size() < DEPTH);
            if (s_rvalid[j] && mq[j].size() > 0 && win[mq[j][0]] < 0) win[mq[j][0]] = j;
        end
        for (int j = 0; j < NOUT; j++) begin
            exp_rdy[j] = 1'b0;
            if (s_rvalid[j]) begin
                if (mq[j].size() == 0) exp_rdy[j] = 1'b1;
                else begin
                    h = mq[j][0];
                    exp_rdy[j] = (win[h] == j) && (!slot_m[h] || s_cready[h]);
                end
            end
        end
        check("avail", 64'(avail_do), 64'(exp_av));
        check("res_ready", 64'(res_ready_do), 64'(exp_rdy));
        check("cpu_valid", 64'(cpu_valid_do), 64'(slot_m));
        check("err", 64'(err_so), 64'(err_m));
        loaded = '0;
        for (int j = 0; j < NOUT; j++) begin
            if (exp_rdy[j]) begin
                if (mq[j].size() == 0) err_m = 1'b1;
                else begin
                    h = mq[j].pop_front();
                    expq[h].push_back(s_rdata[j*WDATA +: WDATA]);
                    loaded[h] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NIN; i++) begin
            if (loaded[i]) slot_m[i] = 1'b1;
            else if (s_cready[i]) slot_m[i] = 1'b0;
        end
        for (int j = 0; j < NOUT; j++) begin
            if (s_alloc[j] && exp_av[j]) mq[j].push_back(int'(s_assid[j*NIN2 +: NIN2]));
        end
        acc = exp_rdy;
    endtask

    task automatic rand_stim(input bit allow_alloc);
        s_alloc  = allow_alloc ? NOUT'($urandom_range(0, 3)) : '0;
        s_assid  = NOUT*NIN2'($urandom);
        s_uready = NOUT'($urandom_range(0, 3) | ($urandom_range(0, 1) ? 3 : 0));
        s_cready = allow_alloc ? NIN'($urandom | $urandom) : '1;
        for (int j = 0; j < NOUT; j++) begin
            if (!(s_rvalid[j] && !acc[j])) begin
                s_rvalid[j] = (mq[j].size() > 0) && (!allow_alloc || $urandom_range(0, 3) != 0);
                s_rdata[j*WDATA +: WDATA] = $urandom;
            end
        end
    endtask

    task automatic idle(input int n);
        s_alloc  = '0;
        s_rvalid = '0;
        s_cready = '1;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        @(negedge clk_ci);
        #1;
        rst_rbi = 1'b0;
        #1;
        check("rst_err", 64'(err_so), 64'(0));
        check("rst_cpu_valid", 64'(cpu_valid_do), 64'(0));
        check("rst_avail", 64'(avail_do), 64'(unit_ready_di));
        alloc_di     = '0;
        res_valid_di = '0;
        for (int j = 0; j < NOUT; j++) mq[j].delete();
        for (int i = 0; i < NIN; i++) expq[i].delete();
        slot_m   = '0;
        err_m    = 1'b0;
        acc      = '0;
        s_alloc  = '0;
        s_rvalid = '0;
        @(negedge clk_ci);
        rst_rbi = 1'b1;
    endtask

    // Monitor: every transfer to a CPU must match the oldest result owed to that CPU.
    initial begin
        logic [WDATA-1:0] e;
        forever begin
            @(negedge clk_ci);
            #4;
            if (rst_rbi) begin
                for (int i = 0; i < NIN; i++) begin
                    if (cpu_valid_do[i] && cpu_ready_di[i]) begin
                        if (expq[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL cpu_unexpected: cpu %0d got %0h expected nothing",
                                     i, cpu_data_do[i*WDATA +: WDATA]);
                        end else begin
                            e = expq[i].pop_front();
                            check("cpu_data", 64'(cpu_data_do[i*WDATA +: WDATA]), 64'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int left;
        unit_ready_di = 2'b11;
        #1;
        check("reset_cpu_valid", 64'(cpu_valid_do), 64'(0));
        check("reset_cpu_data", 64'(cpu_data_do), 64'(0));
        check("reset_err", 64'(err_so), 64'(0));
        check("reset_avail", 64'(avail_do), 64'(2'b11));
        @(negedge clk_ci);
        rst_rbi = 1'b1;

        // Single op: CPU 2 on resource 0.
        s_uready = 2'b11;
        s_cready = '1;
        s_alloc  = 2'b01;
        s_assid  = 4'b0010;
        step();
        s_alloc = '0;
        step();
        step();
        s_rvalid = 2'b01;
        s_rdata  = {32'h0, 32'hA5};
        step();
        check("single_rdy", 64'(res_ready_do), 64'(2'b01));
        s_rvalid = '0;
        step();
        check("single_vld", 64'(cpu_valid_do), 64'(4'b0100));
        check("single_data", 64'(cpu_data_do[2*WDATA +: WDATA]), 64'(32'hA5));
        idle(2);

        // Fill resource 1 with owners 1 then 3.
        s_alloc = 2'b10;
        s_assid = 4'b0100;
        step();
        s_assid = 4'b1100;
        step();
        s_alloc = '0;
        step();
        check("fill_full", 64'(avail_do[1]), 64'(0));
        s_rvalid = 2'b10;
        s_rdata  = {32'h100, 32'h0};
        step();
        s_rdata = {32'h200, 32'h0};
        step();
        check("fill_avail_back", 64'(avail_do[1]), 64'(1));
        idle(3);

        // Collision: both heads owned by CPU 0.
        s_alloc = 2'b11;
        s_assid = 4'b0000;
        step();
        s_alloc  = '0;
        s_rvalid = 2'b11;
        s_rdata  = {32'h22, 32'h11};
        step();
        check("coll_rdy", 64'(res_ready_do), 64'(2'b01));
        s_rvalid = 2'b10;
        step();
        check("coll_rdy2", 64'(res_ready_do), 64'(2'b10));
        check("coll_data1", 64'(cpu_data_do[WDATA-1:0]), 64'(32'h11));
        s_rvalid = '0;
        step();
        check("coll_data2", 64'(cpu_data_do[WDATA-1:0]), 64'(32'h22));
        idle(2);

        // CPU 2 stalls with a result pending; the next one must wait.
        s_alloc = 2'b11;
        s_assid = 4'b1010;
        step();
        s_alloc  = '0;
        s_cready = 4'b1011;
        s_rvalid = 2'b01;
        s_rdata  = {32'h0, 32'h33};
        step();
        s_rvalid = 2'b10;
        s_rdata  = {32'h44, 32'h0};
        step();
        check("stall_hold", 64'(res_ready_do[1]), 64'(0));
        step();
        check("stall_hold2", 64'(cpu_data_do[2*WDATA +: WDATA]), 64'(32'h33));
        s_cready = '1;
        step();
        check("stall_release", 64'(res_ready_do[1]), 64'(1));
        s_rvalid = '0;
        step();
        check("stall_data", 64'(cpu_data_do[2*WDATA +: WDATA]), 64'(32'h44));
        idle(2);

        // Orphan result on empty resource 1.
        s_rvalid = 2'b10;
        s_rdata  = {32'hDEAD, 32'h0};
        step();
        check("orph_rdy", 64'(res_ready_do[1]), 64'(1));
        s_rvalid = '0;
        step();
        check("orph_err", 64'(err_so), 64'(1));

        for (int k = 0; k < 1500; k++) begin
            rand_stim(1'b1);
            step();
        end
        left = 300;
        while (left > 0 && (mq[0].size() + mq[1].size() + expq[0].size() + expq[1].size() +
                            expq[2].size() + expq[3].size()) != 0) begin
            rand_stim(1'b0);
            step();
            left--;
        end
        check("drain_done", 64'(mq[0].size() + mq[1].size()), 64'(0));

        for (int k = 0; k < 300; k++) begin
            rand_stim(1'b1);
            step();
        end
        do_reset();
        s_uready = 2'b11;
        idle(3);
        for (int k = 0; k < 200; k++) begin
            rand_stim(1'b1);
            step();
        end
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
